// File: rtl/mem_request_unit.sv
// Memory request sequencer between control_unit and the caches.
// Drives cache read/write requests, PC/writeback qualifiers, halt and watchdog.
module mem_request_unit #(
    parameter int TIMEOUT = 256,
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               dmemreq,
    input  logic               dmemwreq,
    input  logic               halt,
    output logic               imemREN,
    output logic               dmemREN,
    output logic               dmemWEN,
    output logic               pc_en,
    output logic               wb_en,
    output logic               halt_out,
    output logic               timeout_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        FETCH,
        DATA_RD,
        DATA_WR,
        HALTED
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               halt_q, halt_d;
    logic               terr_q, terr_d;
    logic               hit;
    logic               active;
    logic               pc_en_c;
    logic               wb_en_c;

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        pc_en_c = 1'b0;
        wb_en_c = 1'b0;
        unique case (state_q)
            FETCH: begin
                hit = ihit;
                if (ihit) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else if (dmemreq) begin
                        state_d = DATA_RD;
                    end else if (dmemwreq) begin
                        state_d = DATA_WR;
                    end else begin
                        pc_en_c = 1'b1;
                        wb_en_c = 1'b1;
                    end
                end
            end
            DATA_RD: begin
                hit = dhit;
                if (dhit) begin
                    pc_en_c = 1'b1;
                    wb_en_c = 1'b1;
                    state_d = FETCH;
                end
            end
            DATA_WR: begin
                hit = dhit;
                if (dhit) begin
                    pc_en_c = 1'b1;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State only changes on the expected hit, so clearing on hit covers both.
    always_comb begin
        active = (state_q != HALTED);
        wait_d = wait_q;
        if (!active || hit) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        terr_d  = terr_q | (active && !hit && (wait_q == WAIT_MAX));
        stall_d = stall_q;
        if (active && !pc_en_c && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
        halt_d = halt_q | (state_d == HALTED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            wait_q  <= '0;
            stall_q <= '0;
            halt_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            halt_q  <= halt_d;
            terr_q  <= terr_d;
        end
    end

    // Everything is forced low while reset is held, whatever the state.
    assign imemREN     = !RST && (state_q == FETCH);
    assign dmemREN     = !RST && (state_q == DATA_RD);
    assign dmemWEN     = !RST && (state_q == DATA_WR);
    assign pc_en       = !RST && pc_en_c;
    assign wb_en       = !RST && wb_en_c;
    assign halt_out    = !RST && halt_q;
    assign timeout_err = !RST && terr_q;
    assign stall_cnt   = RST ? '0 : stall_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed scoreboard bench for mem_request_unit.
// Each step pushes the expected outputs and pops them when the DUT is sampled.
module tb_mem_request_unit;

    typedef struct packed {
        logic        imem;
        logic        dren;
        logic        dwen;
        logic        pc;
        logic        wb;
        logic        hlt;
        logic        terr;
        logic [15:0] stall;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ihit = 1'b0;
    logic dhit = 1'b0;
    logic dmemreq = 1'b0;
    logic dmemwreq = 1'b0;
    logic halt = 1'b0;

    logic        imemREN, dmemREN, dmemWEN, pc_en, wb_en, halt_out, timeout_err;
    logic [15:0] stall_cnt;

    logic        s_imem, s_dren, s_dwen, s_pc, s_wb, s_halt, s_terr;
    logic [2:0]  s_stall;

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    mem_request_unit #(.TIMEOUT(8), .STALL_W(16)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemreq(dmemreq), .dmemwreq(dmemwreq), .halt(halt),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pc_en(pc_en), .wb_en(wb_en), .halt_out(halt_out),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance used only for the saturation check.
    mem_request_unit #(.TIMEOUT(256), .STALL_W(3)) dut_sat (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemreq(dmemreq), .dmemwreq(dmemwreq), .halt(halt),
        .imemREN(s_imem), .dmemREN(s_dren), .dmemWEN(s_dwen),
        .pc_en(s_pc), .wb_en(s_wb), .halt_out(s_halt),
        .timeout_err(s_terr), .stall_cnt(s_stall)
    );

    function automatic exp_t mk(input logic im, dr, dw, pc, wb, hl, te,
                                input int st);
        exp_t e;
        e = '{imem: im, dren: dr, dwen: dw, pc: pc, wb: wb,
              hlt: hl, terr: te, stall: 16'(st)};
        return e;
    endfunction

    task automatic step(input string tag, input logic rst, ih, dh, rq, wq, hl,
                        input exp_t e);
        exp_t want;
        exp_t got;
        @(negedge CLK);
        RST = rst; ihit = ih; dhit = dh;
        dmemreq = rq; dmemwreq = wq; halt = hl;
        sb.push_back(e);
        #2;
        got = '{imem: imemREN, dren: dmemREN, dwen: dmemWEN, pc: pc_en,
                wb: wb_en, hlt: halt_out, terr: timeout_err, stall: stall_cnt};
        want = sb.pop_front();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    initial begin
        // reset with hits held high
        step("rst0", 1, 1, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0));
        step("rst1", 1, 1, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0));
        step("rel",  0, 1, 1, 0, 0, 0, mk(1,0,0,1,1,0,0,0));
        // back-to-back ALU instructions
        for (int i = 0; i < 10; i++)
            step($sformatf("add%0d", i), 0, 1, 0, 0, 0, 0, mk(1,0,0,1,1,0,0,0));
        // LW, dhit on entering ihit must not complete the access
        step("lw_ihit", 0, 1, 1, 1, 0, 0, mk(1,0,0,0,0,0,0,0));
        step("lw_w1",   0, 0, 0, 1, 0, 0, mk(0,1,0,0,0,0,0,1));
        step("lw_w2",   0, 1, 0, 1, 0, 0, mk(0,1,0,0,0,0,0,2));
        step("lw_hit",  0, 0, 1, 1, 0, 0, mk(0,1,0,1,1,0,0,3));
        step("lw_next", 0, 1, 0, 0, 0, 0, mk(1,0,0,1,1,0,0,3));
        // SW
        step("sw_ihit", 0, 1, 0, 0, 1, 0, mk(1,0,0,0,0,0,0,3));
        step("sw_hit",  0, 1, 1, 0, 1, 0, mk(0,0,1,1,0,0,0,4));
        // LW+SW together: read wins
        step("rw_ihit", 0, 1, 0, 1, 1, 0, mk(1,0,0,0,0,0,0,4));
        step("rw_w1",   0, 0, 0, 1, 1, 0, mk(0,1,0,0,0,0,0,5));
        step("rw_hit",  0, 0, 1, 1, 1, 0, mk(0,1,0,1,1,0,0,6));
        step("f_miss",  0, 0, 0, 0, 0, 0, mk(1,0,0,0,0,0,0,6));
        step("f_hit",   0, 1, 0, 0, 0, 0, mk(1,0,0,1,1,0,0,7));
        // HALT beats dmemreq, then reset out of HALTED
        step("h_ihit",  0, 1, 0, 1, 0, 1, mk(1,0,0,0,0,0,0,7));
        step("h_1",     0, 1, 1, 1, 1, 1, mk(0,0,0,0,0,1,0,8));
        step("h_2",     0, 1, 1, 0, 0, 0, mk(0,0,0,0,0,1,0,8));
        step("h_rst",   1, 1, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0));
        step("h_post",  0, 0, 0, 0, 0, 0, mk(1,0,0,0,0,0,0,0));
        step("h_post2", 0, 1, 0, 0, 0, 0, mk(1,0,0,1,1,0,0,1));
        // watchdog in DATA_RD
        step("to_ihit", 0, 1, 0, 1, 0, 0, mk(1,0,0,0,0,0,0,1));
        for (int k = 1; k <= 8; k++)
            step($sformatf("to_w%0d", k), 0, 0, 0, 1, 0, 0,
                 mk(0,1,0,0,0,0,0,k + 1));
        step("to_set",  0, 0, 0, 1, 0, 0, mk(0,1,0,0,0,0,1,10));
        step("to_hit",  0, 1, 1, 1, 0, 0, mk(0,1,0,1,1,0,1,11));
        step("to_keep", 0, 1, 0, 0, 0, 0, mk(1,0,0,1,1,0,1,11));
        step("to_rst",  1, 1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0));
        step("to_clr",  0, 1, 0, 0, 0, 0, mk(1,0,0,1,1,0,0,0));
        // watchdog in FETCH plus stall saturation on the narrow instance
        for (int k = 1; k <= 10; k++)
            step($sformatf("fw%0d", k), 0, 0, 0, 0, 0, 0,
                 mk(1,0,0,0,0,0,(k >= 9),k - 1));
        total++;
        assert (s_stall === 3'd7) else begin
            bad++;
            $error("FAIL stall_sat observed=%0d expected=7", s_stall);
        end
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
